// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared playfield geometry, sprite size, game-mode decode and
//                the per-axis bounce/clamp step used by the enemy movers.
//  Contents    : POS_W, PF_* bounds, SPRITE_HALF, DIR_* encodings,
//                game_mode_t, axis_t, decode_mode(), axis_move()
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

   localparam int POS_W       = 10;
   localparam int PF_X_MIN    = 15;
   localparam int PF_X_MAX    = 626;
   localparam int PF_Y_MIN    = 15;
   localparam int PF_Y_MAX    = 466;
   localparam int SPRITE_HALF = 10;

   localparam logic DIR_POS = 1'b1;
   localparam logic DIR_NEG = 1'b0;

   typedef enum logic [1:0] {
      MODE_LOAD = 2'd0,
      MODE_RUN  = 2'd1,
      MODE_HOLD = 2'd2
   } game_mode_t;

   // Centre position and travel direction of one enemy on one axis.
   typedef struct packed {
      logic [POS_W-1:0] pos;
      logic             dir;
   } axis_t;

   // Only the two exact one-hot patterns select LOAD or RUN; anything else,
   // including pause or a malformed combination, holds the game still.
   function automatic game_mode_t decode_mode(input logic menu,
                                              input logic run,
                                              input logic pause);
      game_mode_t mode;
      case ({menu, run, pause})
         3'b100:  mode = MODE_LOAD;
         3'b010:  mode = MODE_RUN;
         default: mode = MODE_HOLD;
      endcase
      return mode;
   endfunction

   // One move along one axis. Compares are done one bit wider than the
   // position so pos+step cannot wrap, and the low test is rearranged to
   // pos < lo+step so pos-step is never formed when it would underflow.
   // A move that would cross a wall lands exactly on it and reverses.
   function automatic axis_t axis_move(input axis_t            cur,
                                       input logic [POS_W-1:0] step,
                                       input logic [POS_W:0]   lo,
                                       input logic [POS_W:0]   hi);
      axis_t          nxt;
      logic [POS_W:0] pos_ext;
      logic [POS_W:0] step_ext;
      pos_ext  = {1'b0, cur.pos};
      step_ext = {1'b0, step};
      nxt      = cur;
      if (cur.dir == DIR_POS) begin
         if (pos_ext + step_ext > hi) begin
            nxt.pos = hi[POS_W-1:0];
            nxt.dir = DIR_NEG;
         end else begin
            nxt.pos = cur.pos + step;
         end
      end else begin
         if (pos_ext < lo + step_ext) begin
            nxt.pos = lo[POS_W-1:0];
            nxt.dir = DIR_POS;
         end else begin
            nxt.pos = cur.pos - step;
         end
      end
      return nxt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/move_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : move_tick_gen
//  Description : Divides clk down to the shared enemy move tick. The counter
//                only advances while enabled, so a paused game keeps its
//                partial interval; clear restarts the interval.
//  Ports       : clk, rst (async, active-high), clear, enable -> tick
//  Revision    : 1.0 - initial release
// ============================================================================
module move_tick_gen #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int               CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] c_last = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_count;
   logic             w_at_last;

   assign w_at_last = (r_count == c_last);
   assign tick      = enable && !clear && w_at_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= w_at_last ? '0 : r_count + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/enemy_swarm_mover.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_swarm_mover
//  Description : Moves NUM_ENEMIES bouncing enemies inside the playfield on a
//                shared move tick, clamping at the walls and ramping the step
//                size (difficulty level) as the game runs.
//  Ports       : clk, rst (async, active-high)
//                gamemenu / gamerun / gamepause  - game-state inputs
//                x, y        - packed centre positions, enemy i at [10*i +: 10]
//                move_strobe - one-cycle pulse after each position update
//                level       - difficulty level, saturating at 15
//  Revision    : 1.0 - initial release
// ============================================================================
module enemy_swarm_mover
   import game_pkg::*;
#(
   parameter int                           NUM_ENEMIES = 3,
   parameter logic [POS_W*NUM_ENEMIES-1:0] INIT_X      = {10'd200, 10'd450, 10'd300},
   parameter logic [POS_W*NUM_ENEMIES-1:0] INIT_Y      = {10'd300, 10'd100, 10'd200},
   parameter int                           X_MIN       = PF_X_MIN,
   parameter int                           X_MAX       = PF_X_MAX,
   parameter int                           Y_MIN       = PF_Y_MIN,
   parameter int                           Y_MAX       = PF_Y_MAX,
   parameter int                           HALF_SIZE   = SPRITE_HALF,
   parameter int                           TICK_DIV    = 100_000_000,
   parameter int                           STEP_INIT   = 20,
   parameter int                           STEP_INC    = 5,
   parameter int                           STEP_MAX    = 40,
   parameter int                           LEVEL_MOVES = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           gamemenu,
   input  logic                           gamerun,
   input  logic                           gamepause,
   output logic [POS_W*NUM_ENEMIES-1:0]   x,
   output logic [POS_W*NUM_ENEMIES-1:0]   y,
   output logic                           move_strobe,
   output logic [3:0]                     level
);

   // Legal centre range on each axis, one bit wider for overflow-free compares.
   localparam logic [POS_W:0] c_x_lo = (POS_W+1)'(X_MIN + HALF_SIZE);
   localparam logic [POS_W:0] c_x_hi = (POS_W+1)'(X_MAX - HALF_SIZE);
   localparam logic [POS_W:0] c_y_lo = (POS_W+1)'(Y_MIN + HALF_SIZE);
   localparam logic [POS_W:0] c_y_hi = (POS_W+1)'(Y_MAX - HALF_SIZE);

   localparam int               MC_W       = (LEVEL_MOVES > 1) ? $clog2(LEVEL_MOVES) : 1;
   localparam logic [MC_W-1:0]  c_mc_last  = MC_W'(LEVEL_MOVES - 1);
   localparam logic [POS_W-1:0] c_step_ini = POS_W'(STEP_INIT);
   localparam logic [POS_W:0]   c_step_inc = (POS_W+1)'(STEP_INC);
   localparam logic [POS_W:0]   c_step_max = (POS_W+1)'(STEP_MAX);
   localparam logic [3:0]       c_lvl_top  = 4'd15;

   // ------------------------------------------------------------------
   // Parameter sanity checks
   // ------------------------------------------------------------------
   if (NUM_ENEMIES < 1 || NUM_ENEMIES > 8) begin : g_bad_count
      $error("enemy_swarm_mover: NUM_ENEMIES=%0d outside 1..8", NUM_ENEMIES);
   end
   if (STEP_MAX >= X_MAX - X_MIN - 2*HALF_SIZE) begin : g_bad_step_x
      $error("enemy_swarm_mover: STEP_MAX=%0d too large for x range", STEP_MAX);
   end
   if (STEP_MAX >= Y_MAX - Y_MIN - 2*HALF_SIZE) begin : g_bad_step_y
      $error("enemy_swarm_mover: STEP_MAX=%0d too large for y range", STEP_MAX);
   end
   if (LEVEL_MOVES < 1) begin : g_bad_level_moves
      $error("enemy_swarm_mover: LEVEL_MOVES must be at least 1");
   end

   // ------------------------------------------------------------------
   // Mode decode and move tick
   // ------------------------------------------------------------------
   game_mode_t w_mode;
   logic       w_load;
   logic       w_run;
   logic       w_tick;

   assign w_mode = decode_mode(gamemenu, gamerun, gamepause);
   assign w_load = (w_mode == MODE_LOAD);
   assign w_run  = (w_mode == MODE_RUN);

   move_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .clear  (w_load),
      .enable (w_run),
      .tick   (w_tick)
   );

   // ------------------------------------------------------------------
   // Difficulty ramp, shared by all enemies
   // ------------------------------------------------------------------
   logic [POS_W-1:0] r_step;
   logic [MC_W-1:0]  r_move_cnt;
   logic             w_level_up;
   logic [POS_W:0]   w_step_sum;
   logic [POS_W-1:0] w_step_next;

   assign w_level_up  = w_tick && (r_move_cnt == c_mc_last);
   assign w_step_sum  = {1'b0, r_step} + c_step_inc;
   assign w_step_next = (w_step_sum > c_step_max) ? c_step_max[POS_W-1:0]
                                                  : w_step_sum[POS_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_step     <= c_step_ini;
         r_move_cnt <= '0;
         level      <= 4'd0;
      end else if (w_load) begin
         r_step     <= c_step_ini;
         r_move_cnt <= '0;
         level      <= 4'd0;
      end else if (w_level_up) begin
         // The raised step is first used by the following tick.
         r_step     <= w_step_next;
         r_move_cnt <= '0;
         level      <= (level == c_lvl_top) ? c_lvl_top : level + 4'd1;
      end else if (w_tick) begin
         r_move_cnt <= r_move_cnt + MC_W'(1);
      end
   end

   // The tick is already suppressed outside RUN, so this is a clean pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         move_strobe <= 1'b0;
      end else begin
         move_strobe <= w_tick;
      end
   end

   // ------------------------------------------------------------------
   // Per-enemy, per-axis position update
   // ------------------------------------------------------------------
   for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_enemy
      localparam logic [POS_W-1:0] c_init_x = INIT_X[POS_W*i +: POS_W];
      localparam logic [POS_W-1:0] c_init_y = INIT_Y[POS_W*i +: POS_W];

      if (int'(c_init_x) < int'(c_x_lo) || int'(c_init_x) > int'(c_x_hi)) begin : g_bad_init_x
         $error("enemy_swarm_mover: INIT_X of enemy %0d outside centre range", i);
      end
      if (int'(c_init_y) < int'(c_y_lo) || int'(c_init_y) > int'(c_y_hi)) begin : g_bad_init_y
         $error("enemy_swarm_mover: INIT_Y of enemy %0d outside centre range", i);
      end

      axis_t r_ax;
      axis_t r_ay;
      axis_t w_ax_next;
      axis_t w_ay_next;

      assign w_ax_next = axis_move(r_ax, r_step, c_x_lo, c_x_hi);
      assign w_ay_next = axis_move(r_ay, r_step, c_y_lo, c_y_hi);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_ax <= '{pos: c_init_x, dir: DIR_POS};
            r_ay <= '{pos: c_init_y, dir: DIR_POS};
         end else if (w_load) begin
            r_ax <= '{pos: c_init_x, dir: DIR_POS};
            r_ay <= '{pos: c_init_y, dir: DIR_POS};
         end else if (w_tick) begin
            r_ax <= w_ax_next;
            r_ay <= w_ay_next;
         end
      end

      assign x[POS_W*i +: POS_W] = r_ax.pos;
      assign y[POS_W*i +: POS_W] = r_ay.pos;
   end

endmodule
`default_nettype wire

// File: tb/tb_enemy_swarm_mover.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enemy_swarm_mover
//  Description : Self-checking bench for enemy_swarm_mover. Three instances
//                share clock and game-state inputs:
//                  0 - defaults (TICK_DIV=4)
//                  1 - enemy 0 starts at x=600, LEVEL_MOVES=2, STEP_MAX=30
//                  2 - narrow x field (X_MAX=80) for low-wall bounces
//                A reference model tracks each enemy as a signed position
//                and a +1/-1 direction, and derives step and level from the
//                number of ticks since the last load.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_swarm_mover;

   localparam int N    = 3;
   localparam int NDUT = 3;
   localparam int TD   = 4;

   localparam logic [29:0] INIT_X_0 = {10'd200, 10'd450, 10'd300};
   localparam logic [29:0] INIT_X_1 = {10'd200, 10'd450, 10'd600};
   localparam logic [29:0] INIT_X_2 = {10'd40,  10'd60,  10'd30};
   localparam logic [29:0] INIT_Y   = {10'd300, 10'd100, 10'd200};

   int cfg_init_x [NDUT][N] = '{'{300, 450, 200}, '{600, 450, 200}, '{30, 60, 40}};
   int cfg_init_y [N]       = '{200, 100, 300};
   int cfg_lm     [NDUT]    = '{16, 2, 16};
   int cfg_smax   [NDUT]    = '{40, 30, 40};
   int cfg_xhi    [NDUT]    = '{616, 616, 70};

   logic        clk = 1'b0;
   logic        rst;
   logic        gamemenu;
   logic        gamerun;
   logic        gamepause;
   logic [29:0] x_o      [NDUT];
   logic [29:0] y_o      [NDUT];
   logic        strobe_o [NDUT];
   logic [3:0]  level_o  [NDUT];

   always #5 clk = ~clk;

   enemy_swarm_mover #(
      .NUM_ENEMIES(3), .INIT_X(INIT_X_0), .INIT_Y(INIT_Y), .TICK_DIV(TD)
   ) dut0 (
      .clk(clk), .rst(rst), .gamemenu(gamemenu), .gamerun(gamerun), .gamepause(gamepause),
      .x(x_o[0]), .y(y_o[0]), .move_strobe(strobe_o[0]), .level(level_o[0])
   );

   enemy_swarm_mover #(
      .NUM_ENEMIES(3), .INIT_X(INIT_X_1), .INIT_Y(INIT_Y), .TICK_DIV(TD),
      .STEP_MAX(30), .LEVEL_MOVES(2)
   ) dut1 (
      .clk(clk), .rst(rst), .gamemenu(gamemenu), .gamerun(gamerun), .gamepause(gamepause),
      .x(x_o[1]), .y(y_o[1]), .move_strobe(strobe_o[1]), .level(level_o[1])
   );

   enemy_swarm_mover #(
      .NUM_ENEMIES(3), .INIT_X(INIT_X_2), .INIT_Y(INIT_Y), .TICK_DIV(TD),
      .X_MAX(80)
   ) dut2 (
      .clk(clk), .rst(rst), .gamemenu(gamemenu), .gamerun(gamerun), .gamepause(gamepause),
      .x(x_o[2]), .y(y_o[2]), .move_strobe(strobe_o[2]), .level(level_o[2])
   );

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   int mx [NDUT][N];
   int my [NDUT][N];
   int dxm[NDUT][N];
   int dym[NDUT][N];
   int tcnt  [NDUT];
   int moves [NDUT];
   bit mstrobe[NDUT];

   int n_cmp = 0;
   int n_err = 0;

   function automatic int step_for(input int d);
      int s;
      s = 20 + (moves[d] / cfg_lm[d]) * 5;
      return (s > cfg_smax[d]) ? cfg_smax[d] : s;
   endfunction

   function automatic logic [3:0] level_for(input int d);
      int l;
      l = moves[d] / cfg_lm[d];
      return (l > 15) ? 4'd15 : 4'(l);
   endfunction

   function automatic logic [29:0] exp_x(input int d);
      logic [29:0] v;
      for (int i = 0; i < N; i++) v[10*i +: 10] = 10'(mx[d][i]);
      return v;
   endfunction

   function automatic logic [29:0] exp_y(input int d);
      logic [29:0] v;
      for (int i = 0; i < N; i++) v[10*i +: 10] = 10'(my[d][i]);
      return v;
   endfunction

   task automatic model_load(input int d);
      for (int i = 0; i < N; i++) begin
         mx[d][i]  = cfg_init_x[d][i];
         my[d][i]  = cfg_init_y[i];
         dxm[d][i] = 1;
         dym[d][i] = 1;
      end
      tcnt[d]    = 0;
      moves[d]   = 0;
      mstrobe[d] = 1'b0;
   endtask

   // Predicts the effect of the next clock edge given the inputs about to be applied.
   task automatic model_clock(input bit m, input bit r, input bit p);
      int st;
      int np;
      for (int d = 0; d < NDUT; d++) begin
         mstrobe[d] = 1'b0;
         if (m && !r && !p) begin
            model_load(d);
         end else if (!m && r && !p) begin
            if (tcnt[d] == TD - 1) begin
               tcnt[d] = 0;
               st = step_for(d);
               for (int i = 0; i < N; i++) begin
                  np = mx[d][i] + dxm[d][i] * st;
                  if (np > cfg_xhi[d]) begin np = cfg_xhi[d]; dxm[d][i] = -1; end
                  else if (np < 25)    begin np = 25;         dxm[d][i] = 1;  end
                  mx[d][i] = np;
                  np = my[d][i] + dym[d][i] * st;
                  if (np > 456)        begin np = 456;        dym[d][i] = -1; end
                  else if (np < 25)    begin np = 25;         dym[d][i] = 1;  end
                  my[d][i] = np;
               end
               moves[d]   = moves[d] + 1;
               mstrobe[d] = 1'b1;
            end else begin
               tcnt[d] = tcnt[d] + 1;
            end
         end
      end
   endtask

   task automatic cyc(input bit m, input bit r, input bit p);
      gamemenu  = m;
      gamerun   = r;
      gamepause = p;
      model_clock(m, r, p);
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------
   task automatic test_reset;
      gamemenu = 0; gamerun = 0; gamepause = 0;
      rst = 1'b1;
      #2;
      for (int d = 0; d < NDUT; d++) model_load(d);
      for (int d = 0; d < NDUT; d++) begin
         n_cmp += 4;
         if (x_o[d] !== exp_x(d)) begin n_err++; $display("FAIL reset_x dut%0d got %h want %h", d, x_o[d], exp_x(d)); end
         if (y_o[d] !== exp_y(d)) begin n_err++; $display("FAIL reset_y dut%0d got %h want %h", d, y_o[d], exp_y(d)); end
         if (strobe_o[d] !== 1'b0) begin n_err++; $display("FAIL reset_strobe dut%0d got %b want 0", d, strobe_o[d]); end
         if (level_o[d] !== 4'd0) begin n_err++; $display("FAIL reset_level dut%0d got %0d want 0", d, level_o[d]); end
      end
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_first_move;
      logic [9:0] ex, ey;
      cyc(1, 0, 0);
      for (int k = 1; k <= 6; k++) begin
         cyc(0, 1, 0);
         ex = (k >= 4) ? 10'd320 : 10'd300;
         ey = (k >= 4) ? 10'd220 : 10'd200;
         n_cmp += 4;
         if (x_o[0][9:0] !== ex) begin n_err++; $display("FAIL first_move_x0 cyc%0d got %0d want %0d", k, x_o[0][9:0], ex); end
         if (y_o[0][9:0] !== ey) begin n_err++; $display("FAIL first_move_y0 cyc%0d got %0d want %0d", k, y_o[0][9:0], ey); end
         if (strobe_o[0] !== (k == 4)) begin n_err++; $display("FAIL first_move_strobe cyc%0d got %b want %b", k, strobe_o[0], (k == 4)); end
         if (x_o[0] !== exp_x(0)) begin n_err++; $display("FAIL first_move_xall cyc%0d got %h want %h", k, x_o[0], exp_x(0)); end
      end
   endtask

   task automatic test_wall_clamp;
      int wall_exp [3] = '{616, 596, 571};
      cyc(1, 0, 0);
      for (int t = 0; t < 3; t++) begin
         repeat (TD) cyc(0, 1, 0);
         n_cmp += 2;
         if (x_o[1][9:0] !== 10'(wall_exp[t])) begin n_err++; $display("FAIL wall_clamp_x0 tick%0d got %0d want %0d", t, x_o[1][9:0], wall_exp[t]); end
         if (x_o[1] !== exp_x(1)) begin n_err++; $display("FAIL wall_clamp_xall tick%0d got %h want %h", t, x_o[1], exp_x(1)); end
      end
   endtask

   task automatic test_low_clamp;
      int low_exp [7] = '{50, 70, 70, 50, 30, 25, 45};
      cyc(1, 0, 0);
      for (int t = 0; t < 7; t++) begin
         repeat (TD) cyc(0, 1, 0);
         n_cmp += 2;
         if (x_o[2][9:0] !== 10'(low_exp[t])) begin n_err++; $display("FAIL low_clamp_x0 tick%0d got %0d want %0d", t, x_o[2][9:0], low_exp[t]); end
         if (x_o[2] !== exp_x(2)) begin n_err++; $display("FAIL low_clamp_xall tick%0d got %h want %h", t, x_o[2], exp_x(2)); end
      end
   endtask

   task automatic test_pause;
      logic [29:0] hx [NDUT];
      logic [29:0] hy [NDUT];
      logic [2:0]  v;
      cyc(1, 0, 0);
      cyc(0, 1, 0);
      cyc(0, 1, 0);
      for (int d = 0; d < NDUT; d++) begin hx[d] = x_o[d]; hy[d] = y_o[d]; end
      for (int k = 0; k < 10; k++) begin
         do v = 3'($urandom_range(0, 7)); while (v == 3'b100 || v == 3'b010);
         cyc(v[2], v[1], v[0]);
         n_cmp += 3;
         if (x_o[0] !== hx[0]) begin n_err++; $display("FAIL pause_x cyc%0d pat%b got %h want %h", k, v, x_o[0], hx[0]); end
         if (y_o[1] !== hy[1]) begin n_err++; $display("FAIL pause_y cyc%0d pat%b got %h want %h", k, v, y_o[1], hy[1]); end
         if (strobe_o[0] !== 1'b0) begin n_err++; $display("FAIL pause_strobe cyc%0d got %b want 0", k, strobe_o[0]); end
      end
      cyc(0, 1, 0);
      n_cmp += 2;
      if (strobe_o[0] !== 1'b0) begin n_err++; $display("FAIL resume_early got %b want 0", strobe_o[0]); end
      if (x_o[0] !== hx[0]) begin n_err++; $display("FAIL resume_early_x got %h want %h", x_o[0], hx[0]); end
      cyc(0, 1, 0);
      n_cmp += 2;
      if (strobe_o[0] !== 1'b1) begin n_err++; $display("FAIL resume_tick got %b want 1", strobe_o[0]); end
      if (x_o[0] !== exp_x(0)) begin n_err++; $display("FAIL resume_tick_x got %h want %h", x_o[0], exp_x(0)); end
   endtask

   task automatic test_ramp;
      int step_exp [7] = '{20, 20, 25, 25, 30, 30, 30};
      int lvl_exp  [7] = '{0, 0, 1, 1, 2, 2, 3};
      int prev;
      cyc(1, 0, 0);
      for (int t = 0; t < 7; t++) begin
         repeat (TD - 1) cyc(0, 1, 0);
         n_cmp += 1;
         if (level_o[1] !== 4'(lvl_exp[t])) begin n_err++; $display("FAIL ramp_level tick%0d got %0d want %0d", t, level_o[1], lvl_exp[t]); end
         prev = int'(y_o[1][9:0]);
         cyc(0, 1, 0);
         n_cmp += 2;
         if (int'(y_o[1][9:0]) - prev !== step_exp[t]) begin n_err++; $display("FAIL ramp_step tick%0d got %0d want %0d", t, int'(y_o[1][9:0]) - prev, step_exp[t]); end
         if (strobe_o[1] !== 1'b1) begin n_err++; $display("FAIL ramp_strobe tick%0d got %b want 1", t, strobe_o[1]); end
      end
      n_cmp += 1;
      if (level_o[1] !== level_for(1)) begin n_err++; $display("FAIL ramp_level_final got %0d want %0d", level_o[1], level_for(1)); end
   endtask

   task automatic test_reset_and_load_on_tick;
      cyc(1, 0, 0);
      repeat (3 * TD + 3) cyc(0, 1, 0);
      // Counter now sits on its last count: this LOAD coincides with a tick.
      cyc(1, 0, 0);
      for (int d = 0; d < NDUT; d++) begin
         n_cmp += 4;
         if (x_o[d] !== exp_x(d)) begin n_err++; $display("FAIL load_tick_x dut%0d got %h want %h", d, x_o[d], exp_x(d)); end
         if (y_o[d] !== exp_y(d)) begin n_err++; $display("FAIL load_tick_y dut%0d got %h want %h", d, y_o[d], exp_y(d)); end
         if (strobe_o[d] !== 1'b0) begin n_err++; $display("FAIL load_tick_strobe dut%0d got %b want 0", d, strobe_o[d]); end
         if (level_o[d] !== 4'd0) begin n_err++; $display("FAIL load_tick_level dut%0d got %0d want 0", d, level_o[d]); end
      end
      cyc(0, 1, 0);
      n_cmp += 1;
      if (strobe_o[0] !== 1'b0) begin n_err++; $display("FAIL load_restart_strobe got %b want 0", strobe_o[0]); end
      repeat (3 * TD + 1) cyc(0, 1, 0);
      // Asynchronous reset between edges while running.
      #2 rst = 1'b1;
      #1;
      for (int d = 0; d < NDUT; d++) model_load(d);
      for (int d = 0; d < NDUT; d++) begin
         n_cmp += 3;
         if (x_o[d] !== exp_x(d)) begin n_err++; $display("FAIL async_rst_x dut%0d got %h want %h", d, x_o[d], exp_x(d)); end
         if (y_o[d] !== exp_y(d)) begin n_err++; $display("FAIL async_rst_y dut%0d got %h want %h", d, y_o[d], exp_y(d)); end
         if (level_o[d] !== 4'd0) begin n_err++; $display("FAIL async_rst_level dut%0d got %0d want 0", d, level_o[d]); end
      end
      @(posedge clk);
      #1;
      n_cmp += 1;
      if (strobe_o[0] !== 1'b0) begin n_err++; $display("FAIL async_rst_strobe got %b want 0", strobe_o[0]); end
      #2 rst = 1'b0;
   endtask

   task automatic test_random;
      int r;
      logic [2:0] v;
      for (int k = 0; k < 900; k++) begin
         r = $urandom_range(0, 99);
         if (r < 2)       v = 3'b100;
         else if (r < 82) v = 3'b010;
         else             v = 3'($urandom_range(0, 7));
         cyc(v[2], v[1], v[0]);
         for (int d = 0; d < NDUT; d++) begin
            n_cmp += 4;
            if (x_o[d] !== exp_x(d)) begin n_err++; $display("FAIL rand_x cyc%0d dut%0d got %h want %h", k, d, x_o[d], exp_x(d)); end
            if (y_o[d] !== exp_y(d)) begin n_err++; $display("FAIL rand_y cyc%0d dut%0d got %h want %h", k, d, y_o[d], exp_y(d)); end
            if (strobe_o[d] !== mstrobe[d]) begin n_err++; $display("FAIL rand_strobe cyc%0d dut%0d got %b want %b", k, d, strobe_o[d], mstrobe[d]); end
            if (level_o[d] !== level_for(d)) begin n_err++; $display("FAIL rand_level cyc%0d dut%0d got %0d want %0d", k, d, level_o[d], level_for(d)); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_move();
      test_wall_clamp();
      test_low_clamp();
      test_pause();
      test_ramp();
      test_reset_and_load_on_tick();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before bench completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
